// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb: direct-mapped cache controller with write-back/write-through, RAM timeout and one-level indirection
module cache_ctrl_wb #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int WRITE_THROUGH = 0,
  parameter int RAM_TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic              cache_dirty,
  input  logic [ADDR_W-1:0] cache_victim_addr,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_we,
  output logic              cache_wsel,
  output logic              cache_dirty_set,
  output logic              cache_clr,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam int CW = $clog2(RAM_TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, CLEAR, LOOKUP, EVICT, FILL, FILL_WR, IND_PTR, ACCESS, WT_RAM, RESP} state_t;
  state_t state, nxt;
  logic [1:0] op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [CW-1:0] cnt;
  logic ind, err, wr, wait_st, tmo;
  always_comb begin
    wr = op == 2'b11;
    wait_st = state inside {EVICT, FILL, WT_RAM};
    tmo = wait_st && !ram_ack && cnt == CW'(RAM_TIMEOUT - 1);
    nxt = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    cache_addr = addr;
    cache_we = 1'b0;
    cache_wsel = 1'b0;
    cache_dirty_set = 1'b0;
    cache_clr = 1'b0;
    ram_req = 1'b0;
    ram_we = 1'b0;
    ram_addr = addr;
    ram_wdata = wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        cache_addr = '0;
        if (req_valid) nxt = req_op == 2'b00 ? CLEAR : req_op == 2'b01 ? RESP : LOOKUP;
      end
      CLEAR: begin
        cache_clr = 1'b1;
        nxt = RESP;
      end
      // a clean miss on a data-phase write needs no fill: the line is a single word
      LOOKUP: nxt = cache_hit ? ACCESS : cache_dirty ? EVICT : (wr && !ind) ? ACCESS : FILL;
      EVICT: begin
        ram_req = 1'b1;
        ram_we = 1'b1;
        ram_addr = cache_victim_addr;
        ram_wdata = cache_rdata;
        nxt = ram_ack ? ((wr && !ind) ? ACCESS : FILL) : tmo ? RESP : EVICT;
      end
      FILL: begin
        ram_req = 1'b1;
        nxt = ram_ack ? FILL_WR : tmo ? RESP : FILL;
      end
      FILL_WR: begin
        cache_we = 1'b1;
        cache_wsel = 1'b1;
        nxt = ACCESS;
      end
      ACCESS: begin
        cache_we = !ind && wr;
        cache_dirty_set = !ind && wr && WRITE_THROUGH == 0;
        nxt = ind ? IND_PTR : (wr && WRITE_THROUGH != 0) ? WT_RAM : RESP;
      end
      IND_PTR: nxt = LOOKUP;
      WT_RAM: begin
        ram_req = 1'b1;
        ram_we = 1'b1;
        nxt = (ram_ack || tmo) ? RESP : WT_RAM;
      end
      RESP: begin
        resp_valid = 1'b1;
        nxt = resp_ready ? IDLE : RESP;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      ind <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (wait_st && nxt == state) ? cnt + 1'b1 : '0;
      if (state == IDLE && req_valid) begin
        op <= req_op;
        addr <= req_addr;
        wdata <= req_wdata;
        ind <= req_indirect && req_op[1];
        rdata <= '0;
        err <= 1'b0;
      end
      if (state == IND_PTR) begin
        addr <= ADDR_W'(cache_rdata);
        ind <= 1'b0;
      end
      if (state == ACCESS && !ind && !wr) rdata <= cache_rdata;
      if (tmo) begin
        err <= 1'b1;
        rdata <= '0;
      end
    end
  end
  assign resp_rdata = rdata;
  assign resp_err = err;
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb_cache_ctrl_wb: vector table over write-back and write-through controllers plus backpressure/reset sequences
module tb_cache_ctrl_wb;
  localparam logic [1:0] OP_CLR = 2'b00, OP_NOP = 2'b01, OP_RD = 2'b10, OP_WR = 2'b11;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic sel = 1'b0, req_valid = 1'b0, req_indirect = 1'b0, resp_ready = 1'b1;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = '0, req_wdata = '0, cache_victim_addr = '0, ram_rdata = '0;
  logic cache_hit = 1'b0, cache_dirty = 1'b0, ram_ack = 1'b0;
  logic [7:0] cmem [256];
  logic o_req_ready [2], o_resp_valid [2], o_resp_err [2], o_cache_we [2], o_cache_wsel [2];
  logic o_cache_dirty_set [2], o_cache_clr [2], o_ram_req [2], o_ram_we [2];
  logic [7:0] o_resp_rdata [2], o_cache_addr [2], o_ram_addr [2], o_ram_wdata [2];
  logic m_req_ready, m_resp_valid, m_resp_err, m_cache_we, m_cache_wsel, m_cache_dirty_set, m_cache_clr, m_ram_req, m_ram_we;
  logic [7:0] m_resp_rdata, m_cache_addr, m_ram_addr, m_ram_wdata, cache_rdata;
  int checks = 0, failures = 0;
  bit got;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_ctrl_wb #(.DATA_W(8), .ADDR_W(8), .WRITE_THROUGH(g), .RAM_TIMEOUT(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 1'(g)), .req_ready(o_req_ready[g]),
      .req_op(req_op), .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(o_resp_valid[g]), .resp_ready(resp_ready), .resp_rdata(o_resp_rdata[g]), .resp_err(o_resp_err[g]),
      .cache_addr(o_cache_addr[g]), .cache_hit(cache_hit), .cache_dirty(cache_dirty),
      .cache_victim_addr(cache_victim_addr), .cache_rdata(cache_rdata), .cache_we(o_cache_we[g]),
      .cache_wsel(o_cache_wsel[g]), .cache_dirty_set(o_cache_dirty_set[g]), .cache_clr(o_cache_clr[g]),
      .ram_req(o_ram_req[g]), .ram_we(o_ram_we[g]), .ram_addr(o_ram_addr[g]), .ram_wdata(o_ram_wdata[g]),
      .ram_ack(ram_ack), .ram_rdata(ram_rdata)
    );
  end
  assign m_req_ready = o_req_ready[sel];
  assign m_resp_valid = o_resp_valid[sel];
  assign m_resp_err = o_resp_err[sel];
  assign m_resp_rdata = o_resp_rdata[sel];
  assign m_cache_addr = o_cache_addr[sel];
  assign m_cache_we = o_cache_we[sel];
  assign m_cache_wsel = o_cache_wsel[sel];
  assign m_cache_dirty_set = o_cache_dirty_set[sel];
  assign m_cache_clr = o_cache_clr[sel];
  assign m_ram_req = o_ram_req[sel];
  assign m_ram_we = o_ram_we[sel];
  assign m_ram_addr = o_ram_addr[sel];
  assign m_ram_wdata = o_ram_wdata[sel];
  assign cache_rdata = cmem[m_cache_addr];
  typedef struct {
    bit sel; logic [1:0] op; bit ind; logic [7:0] addr, wdata; bit hit, dirty; logic [7:0] victim, ram_rd; int lat;
    logic [7:0] pa, pd, qa, qd;
    int e_lat; logic [7:0] e_rdata; bit e_err; logic [7:0] e_caddr; int e_req, e_we; bit e_ds; int e_wrn; logic [7:0] e_wa, e_wd; int e_clr;
  } vec_t;
  vec_t vecs [13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic preload(input logic [7:0] pa, pd, qa, qd);
    for (int i = 0; i < 256; i++) cmem[i] = 8'h00;
    cmem[pa] = pd;
    cmem[qa] = qd;
  endtask
  task automatic issue(input logic [1:0] op, input bit ind, input logic [7:0] addr, wdata);
    @(negedge clk);
    chk("accept_ready", 32'(m_req_ready), 32'd1);
    req_op = op;
    req_indirect = ind;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic run(input int n, input vec_t v);
    int rc, req_n, we_n, wr_n, clr_n, lat;
    bit ds, ok, er;
    logic [7:0] wa, wd, rd, ca;
    {rc, req_n, we_n, wr_n, clr_n, lat, ds, ok, er, wa, wd, rd, ca} = '0;
    preload(v.pa, v.pd, v.qa, v.qd);
    sel = v.sel;
    cache_hit = v.hit;
    cache_dirty = v.dirty;
    cache_victim_addr = v.victim;
    ram_rdata = v.ram_rd;
    issue(v.op, v.ind, v.addr, v.wdata);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ram_ack) begin
        ram_ack = 1'b0;
        rc = 0;
      end
      if (m_ram_req) begin
        rc++;
        req_n++;
        if (v.lat >= 0 && rc == v.lat + 1) begin
          ram_ack = 1'b1;
          if (m_ram_we) begin
            if (wr_n == 0) {wa, wd} = {m_ram_addr, m_ram_wdata};
            wr_n++;
          end
        end
      end else rc = 0;
      if (m_cache_we) begin
        we_n++;
        ds = ds | m_cache_dirty_set;
        cmem[m_cache_addr] = m_cache_wsel ? v.ram_rd : v.wdata;
      end
      if (m_cache_clr) clr_n++;
      if (m_resp_valid) begin
        {ok, lat, rd, er, ca} = {1'b1, k, m_resp_rdata, m_resp_err, m_cache_addr};
        break;
      end
    end
    ram_ack = 1'b0;
    chk($sformatf("v%0d_resp_seen", n), 32'(ok), 32'd1);
    chk($sformatf("v%0d_latency", n), lat, v.e_lat);
    if (v.op == OP_RD || v.op == OP_NOP) chk($sformatf("v%0d_rdata", n), 32'(rd), 32'(v.e_rdata));
    chk($sformatf("v%0d_err", n), 32'(er), 32'(v.e_err));
    chk($sformatf("v%0d_cache_addr", n), 32'(ca), 32'(v.e_caddr));
    chk($sformatf("v%0d_ram_req_cycles", n), req_n, v.e_req);
    chk($sformatf("v%0d_cache_we", n), we_n, v.e_we);
    chk($sformatf("v%0d_dirty_set", n), 32'(ds), 32'(v.e_ds));
    chk($sformatf("v%0d_ram_writes", n), wr_n, v.e_wrn);
    if (v.e_wrn > 0) chk($sformatf("v%0d_ram_wr_addr_data", n), {16'h0, wa, wd}, {16'h0, v.e_wa, v.e_wd});
    chk($sformatf("v%0d_clr", n), clr_n, v.e_clr);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    vecs[0]  = '{0, OP_RD,  0, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00, -1, 8'h10, 8'h5A, 8'hFF, 8'h00, 3,  8'h5A, 0, 8'h10, 0, 0, 0, 0, 8'h00, 8'h00, 0};
    vecs[1]  = '{0, OP_RD,  0, 8'h20, 8'h00, 0, 1, 8'h44, 8'h33, 2,  8'h20, 8'h11, 8'hFF, 8'h00, 10, 8'h33, 0, 8'h20, 6, 1, 0, 1, 8'h44, 8'h11, 0};
    vecs[2]  = '{0, OP_WR,  0, 8'h08, 8'h77, 1, 0, 8'h00, 8'h00, -1, 8'h08, 8'h01, 8'hFF, 8'h00, 3,  8'h00, 0, 8'h08, 0, 1, 1, 0, 8'h00, 8'h00, 0};
    vecs[3]  = '{1, OP_WR,  0, 8'h08, 8'h77, 1, 0, 8'h00, 8'h00, 1,  8'h08, 8'h01, 8'hFF, 8'h00, 5,  8'h00, 0, 8'h08, 2, 1, 0, 1, 8'h08, 8'h77, 0};
    vecs[4]  = '{0, OP_RD,  1, 8'h30, 8'h00, 1, 0, 8'h00, 8'h00, -1, 8'h30, 8'h90, 8'h90, 8'hAB, 6,  8'hAB, 0, 8'h90, 0, 0, 0, 0, 8'h00, 8'h00, 0};
    vecs[5]  = '{0, OP_RD,  0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00, -1, 8'h50, 8'h00, 8'hFF, 8'h00, 6,  8'h00, 1, 8'h50, 4, 0, 0, 0, 8'h00, 8'h00, 0};
    vecs[6]  = '{0, OP_RD,  0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h66, 3,  8'h50, 8'h00, 8'hFF, 8'h00, 8,  8'h66, 0, 8'h50, 4, 1, 0, 0, 8'h00, 8'h00, 0};
    vecs[7]  = '{0, OP_NOP, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, -1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1,  8'h00, 0, 8'h12, 0, 0, 0, 0, 8'h00, 8'h00, 0};
    vecs[8]  = '{0, OP_CLR, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, -1, 8'hFF, 8'h00, 8'hFF, 8'h00, 2,  8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1};
    vecs[9]  = '{0, OP_WR,  0, 8'h60, 8'h44, 0, 0, 8'h00, 8'h00, -1, 8'hFF, 8'h00, 8'hFF, 8'h00, 3,  8'h00, 0, 8'h60, 0, 1, 1, 0, 8'h00, 8'h00, 0};
    vecs[10] = '{0, OP_WR,  0, 8'h60, 8'h45, 0, 1, 8'h61, 8'h00, 0,  8'h60, 8'h22, 8'hFF, 8'h00, 4,  8'h00, 0, 8'h60, 1, 1, 1, 1, 8'h61, 8'h22, 0};
    vecs[11] = '{0, OP_WR,  1, 8'h30, 8'h5C, 1, 0, 8'h00, 8'h00, -1, 8'h30, 8'h90, 8'hFF, 8'h00, 6,  8'h00, 0, 8'h90, 0, 1, 1, 0, 8'h00, 8'h00, 0};
    vecs[12] = '{1, OP_WR,  0, 8'h08, 8'h77, 1, 0, 8'h00, 8'h00, -1, 8'h08, 8'h01, 8'hFF, 8'h00, 7,  8'h00, 1, 8'h08, 4, 1, 0, 0, 8'h00, 8'h00, 0};
    preload(8'hFF, 8'h00, 8'hFF, 8'h00);
    #12;
    chk("reset_req_ready", 32'(m_req_ready), 32'd1);
    chk("reset_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("reset_ram_req", 32'(m_ram_req), 32'd0);
    chk("reset_cache_we_clr", {30'h0, m_cache_we, m_cache_clr}, 32'd0);
    chk("reset_cache_addr", 32'(m_cache_addr), 32'd0);
    chk("reset_resp_data_err", {23'h0, m_resp_err, m_resp_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) run(i, vecs[i]);
    // backpressure: response must hold steady while resp_ready is low
    sel = 1'b0;
    preload(8'h10, 8'h5A, 8'hFF, 8'h00);
    cache_hit = 1'b1;
    cache_dirty = 1'b0;
    resp_ready = 1'b0;
    issue(OP_RD, 1'b0, 8'h10, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = m_resp_valid;
    end
    chk("bp_resp_seen", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(m_resp_valid), 32'd1);
      chk("bp_hold_rdata", 32'(m_resp_rdata), 32'h5A);
      chk("bp_hold_req_ready", 32'(m_req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(m_resp_valid), 32'd0);
    chk("bp_release_req_ready", 32'(m_req_ready), 32'd1);
    // reset during an eviction whose ack never comes
    preload(8'h20, 8'h11, 8'hFF, 8'h00);
    cache_hit = 1'b0;
    cache_dirty = 1'b1;
    cache_victim_addr = 8'h44;
    issue(OP_RD, 1'b0, 8'h20, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = m_ram_req;
    end
    chk("rst_evict_req_seen", 32'(got), 32'd1);
    chk("rst_evict_we_addr_data", {15'h0, m_ram_we, m_ram_addr, m_ram_wdata}, {15'h0, 1'b1, 8'h44, 8'h11});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ram_req", 32'(m_ram_req), 32'd0);
    chk("rst_async_req_ready", 32'(m_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_req_ready", 32'(m_req_ready), 32'd1);
    chk("rst_after_resp_ram", {30'h0, m_resp_valid, m_ram_req}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
